// File: rtl/uart_prog_pkg.sv
// Shared constants for the UART program loader: frame bytes and FSM state encoding.
package uart_prog_pkg;

    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_CSUM = 3'd5;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] value);
        return acc + value;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte stream in, instruction-memory write port and status pulses out.
interface uart_prog_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  we;
    logic                  prog;
    logic                  busy;
    logic                  done;
    logic                  err_csum;
    logic                  err_cmd;
    logic                  err_timeout;

    modport slave (
        input  rx_byte, rx_valid,
        output addr, data, we, prog, busy, done, err_csum, err_cmd, err_timeout
    );

    modport master (
        output rx_byte, rx_valid,
        input  addr, data, we, prog, busy, done, err_csum, err_cmd, err_timeout
    );
endinterface

// File: rtl/uart_prog_word_asm.sv
// Little-endian byte-to-word assembler; word/word_valid present the completed word
// combinationally on the strobe of its final byte so the caller can register it.
module uart_prog_word_asm #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_data,
    input  logic                  strobe,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);
    localparam int WB = DATA_WIDTH / 8;
    localparam int CW = (WB > 1) ? $clog2(WB) : 1;

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] acc;

    always_comb begin
        word = acc;
        word[cnt*8 +: 8] = byte_data;
        word_valid = strobe && (cnt == CW'(WB - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            acc <= '0;
        end else if (clear) begin
            cnt <= '0;
            acc <= '0;
        end else if (strobe) begin
            acc <= word;
            cnt <= word_valid ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_prog_loader.sv
// Frame parser that writes program words received over UART into instruction memory
// and holds the CPU in program mode until a good RUN frame arrives.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic               clk,
    input logic               reset,
    uart_prog_loader_if.slave bus
);
    // state | meaning
    // IDLE  | hunting for SYNC, other bytes dropped
    // CMD   | expecting command byte
    // ADDR  | collecting little-endian base address bytes
    // LEN   | expecting word count minus one
    // DATA  | assembling payload words, one write per word
    // CSUM  | expecting checksum byte
    localparam int AB  = (ADDR_WIDTH + 7) / 8;
    localparam int ACW = (AB > 1) ? $clog2(AB) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    logic [2:0]            state, state_n;
    logic [7:0]            csum, csum_sum;
    logic [ADDR_WIDTH-1:0] base;
    logic [AB*8-1:0]       addr_wide;
    logic [ACW-1:0]        addr_idx;
    logic [7:0]            len, word_cnt;
    logic                  is_run;
    logic [TW-1:0]         timer;
    logic                  expire;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_valid;
    logic                  last_word;
    logic                  done_n, err_csum_n, err_cmd_n, err_timeout_n;

    uart_prog_word_asm #(.DATA_WIDTH(DATA_WIDTH)) u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (bus.rx_byte),
        .strobe     (bus.rx_valid && state == S_DATA),
        .clear      (state != S_DATA),
        .word       (word),
        .word_valid (word_valid)
    );

    // A byte arriving on the expiry cycle reloads the timer instead of timing out.
    assign expire    = (state != S_IDLE) && !bus.rx_valid && (timer == '0);
    assign csum_sum  = csum_add(csum, bus.rx_byte);
    assign last_word = word_valid && (word_cnt == len);

    always_comb begin
        addr_wide = '0;
        addr_wide[ADDR_WIDTH-1:0] = base;
        addr_wide[addr_idx*8 +: 8] = bus.rx_byte;
    end

    always_comb begin
        state_n       = state;
        done_n        = 1'b0;
        err_csum_n    = 1'b0;
        err_cmd_n     = 1'b0;
        err_timeout_n = 1'b0;
        if (expire) begin
            state_n       = S_IDLE;
            err_timeout_n = 1'b1;
        end else if (bus.rx_valid) begin
            case (state)
                S_IDLE: if (bus.rx_byte == SYNC) state_n = S_CMD;
                S_CMD: begin
                    if (bus.rx_byte == CMD_WRITE) begin
                        state_n = S_ADDR;
                    end else if (bus.rx_byte == CMD_RUN) begin
                        state_n = S_CSUM;
                    end else begin
                        state_n   = S_IDLE;
                        err_cmd_n = 1'b1;
                    end
                end
                S_ADDR: if (addr_idx == ACW'(AB - 1)) state_n = S_LEN;
                S_LEN:  state_n = S_DATA;
                S_DATA: if (last_word) state_n = S_CSUM;
                S_CSUM: begin
                    state_n = S_IDLE;
                    if (csum_sum != 8'h00) err_csum_n = 1'b1;
                    else if (is_run)       done_n     = 1'b1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            csum            <= '0;
            base            <= '0;
            addr_idx        <= '0;
            len             <= '0;
            word_cnt        <= '0;
            is_run          <= 1'b0;
            timer           <= '0;
            bus.addr        <= '0;
            bus.data        <= '0;
            bus.we          <= 1'b0;
            bus.prog        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err_csum    <= 1'b0;
            bus.err_cmd     <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            state           <= state_n;
            bus.busy        <= (state_n != S_IDLE);
            bus.done        <= done_n;
            bus.err_csum    <= err_csum_n;
            bus.err_cmd     <= err_cmd_n;
            bus.err_timeout <= err_timeout_n;
            bus.we          <= 1'b0;

            if (bus.rx_valid)
                timer <= TW'(TIMEOUT_CYCLES - 1);
            else if (state != S_IDLE && timer != '0)
                timer <= timer - 1'b1;

            if (bus.rx_valid) begin
                case (state)
                    S_IDLE: csum <= '0;
                    S_CMD: begin
                        csum     <= csum_sum;
                        is_run   <= (bus.rx_byte == CMD_RUN);
                        addr_idx <= '0;
                        if (bus.rx_byte == CMD_WRITE) bus.prog <= 1'b1;
                    end
                    S_ADDR: begin
                        csum     <= csum_sum;
                        base     <= addr_wide[ADDR_WIDTH-1:0];
                        addr_idx <= addr_idx + 1'b1;
                    end
                    S_LEN: begin
                        csum     <= csum_sum;
                        len      <= bus.rx_byte;
                        word_cnt <= '0;
                    end
                    S_DATA: begin
                        csum <= csum_sum;
                        if (word_valid) begin
                            bus.we   <= 1'b1;
                            bus.addr <= base + ADDR_WIDTH'(word_cnt);
                            bus.data <= word;
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                    S_CSUM: if (done_n) bus.prog <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule
